// File: rtl/pep_mmacc_boram_rd_ctrl_pkg.sv
// Shared types and constants for the mmacc body-RAM read scheduler.
// Contents: PID sizing, outstanding-read limit, FSM state enum, read command payload.
package pep_mmacc_boram_rd_ctrl_pkg;

    localparam int unsigned TOTAL_PBS_NB = 32;
    localparam int unsigned PID_W        = $clog2(TOTAL_PBS_NB);
    localparam int unsigned OUTSTD_MAX   = 4;
    localparam int unsigned OUTSTD_W     = $clog2(OUTSTD_MAX + 1);

    typedef logic [PID_W-1:0] pid_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } boram_rd_state_e;

    // Read command as presented to the body RAM.
    typedef struct packed {
        pid_t pid;
        logic parity;
    } boram_rd_cmd_t;

endpackage

// File: rtl/pep_mmacc_boram_credit.sv
// Outstanding-read credit counter with sticky underflow flag.
// Ports: clk, a_rst_n; inc (read issued), dec (data returned);
//        cnt (registered count), cnt_nxt_c (next count, combinational),
//        err_underflow (sticky: dec seen while cnt==0).
module pep_mmacc_boram_credit #(
    parameter int unsigned MAX = 4,
    parameter int unsigned W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         a_rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt_c,
    output logic         err_underflow
);

    logic dec_ok;
    logic underflow;

    // A return with nothing outstanding is an error and does not move the count.
    assign dec_ok    = dec && (cnt != '0);
    assign underflow = dec && (cnt == '0);

    always_comb begin
        cnt_nxt_c = cnt;
        case ({inc, dec_ok})
            2'b10:   cnt_nxt_c = cnt + W'(1);
            2'b01:   cnt_nxt_c = cnt - W'(1);
            default: cnt_nxt_c = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            cnt           <= '0;
            err_underflow <= 1'b0;
        end else begin
            cnt <= cnt_nxt_c;
            if (underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pep_mmacc_boram_rd_ctrl.sv
// Read-command scheduler in front of the mmacc body RAM.
// Accepts sample-extract read requests by PID, tracks a per-PID read parity,
// issues credit-limited read commands and sequences cache flushes so they only
// complete with no reads in flight.
// Ports: clk, a_rst_n; reset_cache (flush pulse); cmd_pid/cmd_vld/cmd_rdy (request,
//        cmd_rdy is combinational); boram_rd_pid/parity/vld/rdy (read command);
//        rdata_ack (one per returned read); outstd_cnt; flush_done (pulse);
//        err_underflow (sticky).
// Optional: PEP_MMACC_BORAM_RD_STATS_EN adds stat_rd_cnt and stat_stall_cycles.
module pep_mmacc_boram_rd_ctrl
    import pep_mmacc_boram_rd_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                a_rst_n,
    input  logic                reset_cache,
    input  logic [PID_W-1:0]    cmd_pid,
    input  logic                cmd_vld,
    output logic                cmd_rdy,
    output logic [PID_W-1:0]    boram_rd_pid,
    output logic                boram_rd_parity,
    output logic                boram_rd_vld,
    input  logic                boram_rd_rdy,
    input  logic                rdata_ack,
    output logic [OUTSTD_W-1:0] outstd_cnt,
    output logic                flush_done,
    output logic                err_underflow
`ifdef PEP_MMACC_BORAM_RD_STATS_EN
    ,
    output logic [31:0]         stat_rd_cnt,
    output logic [31:0]         stat_stall_cycles
`endif
);

    boram_rd_state_e         state_q;
    boram_rd_state_e         state_d;
    logic [TOTAL_PBS_NB-1:0] parity_q;
    logic                    flush_pend_q;
    logic [OUTSTD_W-1:0]     cnt_nxt;
    logic                    issue;
    logic                    credit_ok;
    logic                    rd_par_c;
    logic                    rdy_c;
    logic                    load;
    logic                    flush_fin;
    logic                    set_pend;
    logic                    clr_pend;

    assign issue     = boram_rd_vld && boram_rd_rdy;
    assign credit_ok = cnt_nxt < OUTSTD_W'(OUTSTD_MAX);
    // Bypass: a same-PID command loaded while the previous one issues sees the toggle.
    assign rd_par_c  = parity_q[cmd_pid] ^ (issue && (boram_rd_pid == cmd_pid));
    assign cmd_rdy   = rdy_c && a_rst_n;

    pep_mmacc_boram_credit #(
        .MAX (OUTSTD_MAX),
        .W   (OUTSTD_W)
    ) u_credit (
        .clk           (clk),
        .a_rst_n       (a_rst_n),
        .inc           (issue),
        .dec           (rdata_ack),
        .cnt           (outstd_cnt),
        .cnt_nxt_c     (cnt_nxt),
        .err_underflow (err_underflow)
    );

    // Next state, request acceptance and flush sequencing.
    always_comb begin
        state_d   = state_q;
        rdy_c     = 1'b0;
        load      = 1'b0;
        flush_fin = 1'b0;
        set_pend  = 1'b0;
        clr_pend  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rdy_c = !reset_cache;
                if (reset_cache) begin
                    if (cnt_nxt == '0) begin
                        flush_fin = 1'b1;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end else if (cmd_vld) begin
                    load    = 1'b1;
                    state_d = credit_ok ? ST_REQ : ST_STALL;
                end
            end
            ST_REQ: begin
                if (boram_rd_rdy) begin
                    // No new command once a flush is requested, so the flush follows this issue.
                    rdy_c = !reset_cache && !flush_pend_q && credit_ok;
                    if (cmd_vld && rdy_c) begin
                        load    = 1'b1;
                        state_d = ST_REQ;
                    end else if (reset_cache || flush_pend_q) begin
                        clr_pend = 1'b1;
                        state_d  = ST_FLUSH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    set_pend = reset_cache;
                end
            end
            ST_STALL: begin
                set_pend = reset_cache;
                if (credit_ok) begin
                    state_d = ST_REQ;
                end
            end
            ST_FLUSH: begin
                if (cnt_nxt == '0) begin
                    flush_fin = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, command register, parity table and flush flags.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q         <= ST_IDLE;
            parity_q        <= '0;
            flush_pend_q    <= 1'b0;
            boram_rd_vld    <= 1'b0;
            boram_rd_pid    <= '0;
            boram_rd_parity <= 1'b0;
            flush_done      <= 1'b0;
        end else begin
            state_q      <= state_d;
            boram_rd_vld <= (state_d == ST_REQ);
            flush_done   <= flush_fin;
            if (load) begin
                boram_rd_pid    <= cmd_pid;
                boram_rd_parity <= rd_par_c;
            end
            if (flush_fin) begin
                parity_q <= '0;
            end else if (issue) begin
                parity_q[boram_rd_pid] <= ~parity_q[boram_rd_pid];
            end
            if (clr_pend) begin
                flush_pend_q <= 1'b0;
            end else if (set_pend) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

`ifdef PEP_MMACC_BORAM_RD_STATS_EN
    // Issued-read count (wrapping) and stall-cycle count (saturating).
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            stat_rd_cnt       <= '0;
            stat_stall_cycles <= '0;
        end else if (flush_fin) begin
            stat_rd_cnt       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (issue) begin
                stat_rd_cnt <= stat_rd_cnt + 32'd1;
            end
            if ((state_q == ST_STALL) && (stat_stall_cycles != '1)) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pep_mmacc_boram_rd_ctrl.sv
// Self-checking bench for pep_mmacc_boram_rd_ctrl: table-driven vectors,
// hand-written multi-cycle sequences and a random run against a parity model.
module tb_pep_mmacc_boram_rd_ctrl;
    import pep_mmacc_boram_rd_ctrl_pkg::*;

    localparam int unsigned N_RAND = 10000;
    localparam int unsigned RAND_BUDGET = 90000;

    logic                clk = 1'b0;
    logic                a_rst_n;
    logic                reset_cache;
    logic [PID_W-1:0]    cmd_pid;
    logic                cmd_vld;
    logic                cmd_rdy;
    logic [PID_W-1:0]    boram_rd_pid;
    logic                boram_rd_parity;
    logic                boram_rd_vld;
    logic                boram_rd_rdy;
    logic                rdata_ack;
    logic [OUTSTD_W-1:0] outstd_cnt;
    logic                flush_done;
    logic                err_underflow;
`ifdef PEP_MMACC_BORAM_RD_STATS_EN
    logic [31:0]         stat_rd_cnt;
    logic [31:0]         stat_stall_cycles;
`endif

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pep_mmacc_boram_rd_ctrl dut (
        .clk             (clk),
        .a_rst_n         (a_rst_n),
        .reset_cache     (reset_cache),
        .cmd_pid         (cmd_pid),
        .cmd_vld         (cmd_vld),
        .cmd_rdy         (cmd_rdy),
        .boram_rd_pid    (boram_rd_pid),
        .boram_rd_parity (boram_rd_parity),
        .boram_rd_vld    (boram_rd_vld),
        .boram_rd_rdy    (boram_rd_rdy),
        .rdata_ack       (rdata_ack),
        .outstd_cnt      (outstd_cnt),
        .flush_done      (flush_done),
        .err_underflow   (err_underflow)
`ifdef PEP_MMACC_BORAM_RD_STATS_EN
        ,
        .stat_rd_cnt       (stat_rd_cnt),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    typedef struct {
        logic       rc;
        logic       vld;
        logic [4:0] pid;
        logic       rdy;
        logic       ack;
        logic       e_rdy;
        logic       e_vld;
        logic [4:0] e_pid;
        logic       e_par;
        logic [2:0] e_cnt;
        logic       e_err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic rc, logic vld, logic [4:0] pid, logic rdy, logic ack,
                                logic e_rdy, logic e_vld, logic [4:0] e_pid, logic e_par,
                                logic [2:0] e_cnt, logic e_err);
        vec_t v;
        v.rc = rc; v.vld = vld; v.pid = pid; v.rdy = rdy; v.ack = ack;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_pid = e_pid; v.e_par = e_par;
        v.e_cnt = e_cnt; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and let combinational outputs settle.
    task automatic drive(input logic rc, input logic v, input logic [4:0] p,
                         input logic rdy, input logic ack);
        @(negedge clk);
        reset_cache  = rc;
        cmd_vld      = v;
        cmd_pid      = p;
        boram_rd_rdy = rdy;
        rdata_ack    = ack;
        #1;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    // Random-run state
    logic [TOTAL_PBS_NB-1:0] model_par;
    int                      exp_q[$];
    int                      due_q[$];
    int                      model_cnt;
    int                      sent;
    int                      issued;
    int                      cyc;
    logic                    pend;
    logic [4:0]              pend_pid;
    logic                    do_issue;
    logic                    do_ack;
    int                      exp_pid;

    initial begin
        a_rst_n      = 1'b0;
        reset_cache  = 1'b0;
        cmd_vld      = 1'b0;
        cmd_pid      = '0;
        boram_rd_rdy = 1'b0;
        rdata_ack    = 1'b0;

        // Vector table: {inputs} -> {cmd_rdy during cycle, registered outputs after edge}
        vt.push_back(mk(0,1,3,1,0, 1,1,3,0,0,0));
        vt.push_back(mk(0,1,3,1,0, 1,1,3,1,1,0));
        vt.push_back(mk(0,0,0,1,0, 1,0,0,0,2,0));
        vt.push_back(mk(0,0,0,1,1, 1,0,0,0,1,0));
        vt.push_back(mk(0,0,0,1,1, 1,0,0,0,0,0));
        vt.push_back(mk(0,1,5,1,0, 1,1,5,0,0,0));
        vt.push_back(mk(0,1,5,1,0, 1,1,5,1,1,0));
        vt.push_back(mk(0,1,5,1,0, 1,1,5,0,2,0));
        vt.push_back(mk(0,1,5,1,0, 1,1,5,1,3,0));
        vt.push_back(mk(0,1,5,1,0, 0,0,0,0,4,0));
        vt.push_back(mk(0,1,5,1,0, 1,0,0,0,4,0));
        vt.push_back(mk(0,0,0,1,0, 0,0,0,0,4,0));
        vt.push_back(mk(0,0,0,1,1, 0,1,5,0,3,0));
        vt.push_back(mk(0,0,0,1,0, 0,0,0,0,4,0));
        vt.push_back(mk(0,0,0,1,1, 1,0,0,0,3,0));
        vt.push_back(mk(0,0,0,1,1, 1,0,0,0,2,0));
        vt.push_back(mk(0,0,0,1,1, 1,0,0,0,1,0));
        vt.push_back(mk(0,0,0,1,1, 1,0,0,0,0,0));
        vt.push_back(mk(0,0,0,1,1, 1,0,0,0,0,1));
        vt.push_back(mk(0,0,0,0,0, 1,0,0,0,0,1));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_rdy", 32'(cmd_rdy), 0);
        chk("rst_vld", 32'(boram_rd_vld), 0);
        chk("rst_pid", 32'(boram_rd_pid), 0);
        chk("rst_par", 32'(boram_rd_parity), 0);
        chk("rst_cnt", 32'(outstd_cnt), 0);
        chk("rst_fd", 32'(flush_done), 0);
        chk("rst_err", 32'(err_underflow), 0);
        @(negedge clk);
        a_rst_n = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].rc, vt[i].vld, vt[i].pid, vt[i].rdy, vt[i].ack);
            chk($sformatf("vec%0d_cmd_rdy", i), 32'(cmd_rdy), 32'(vt[i].e_rdy));
            edge_settle();
            chk($sformatf("vec%0d_vld", i), 32'(boram_rd_vld), 32'(vt[i].e_vld));
            if (vt[i].e_vld) begin
                chk($sformatf("vec%0d_pid", i), 32'(boram_rd_pid), 32'(vt[i].e_pid));
                chk($sformatf("vec%0d_par", i), 32'(boram_rd_parity), 32'(vt[i].e_par));
            end
            chk($sformatf("vec%0d_cnt", i), 32'(outstd_cnt), 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d_fd", i), 32'(flush_done), 0);
            chk($sformatf("vec%0d_err", i), 32'(err_underflow), 32'(vt[i].e_err));
        end

        // Command held with boram_rd_rdy low: outputs stable, no acceptance, one issue.
        drive(0, 1, 7, 0, 0);
        chk("hold_accept_rdy", 32'(cmd_rdy), 1);
        edge_settle();
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 9, 0, 0);
            chk("hold_cmd_rdy", 32'(cmd_rdy), 0);
            edge_settle();
            chk("hold_vld", 32'(boram_rd_vld), 1);
            chk("hold_pid", 32'(boram_rd_pid), 7);
            chk("hold_par", 32'(boram_rd_parity), 0);
        end
        drive(0, 0, 0, 1, 0);
        edge_settle();
        chk("hold_issue_vld", 32'(boram_rd_vld), 0);
        chk("hold_issue_cnt", 32'(outstd_cnt), 1);
        drive(0, 0, 0, 1, 0);
        edge_settle();
        chk("hold_single_issue", 32'(outstd_cnt), 1);

        // Flush with three outstanding; pid 3 parity goes 1 -> cleared.
        drive(0, 1, 3, 1, 0);
        edge_settle();
        chk("fl_pid3_par", 32'(boram_rd_parity), 0);
        drive(0, 1, 9, 1, 0);
        edge_settle();
        chk("fl_pid9_pid", 32'(boram_rd_pid), 9);
        drive(0, 0, 0, 1, 0);
        edge_settle();
        chk("fl_cnt3", 32'(outstd_cnt), 3);
        drive(1, 0, 0, 1, 0);
        chk("fl_req_rdy", 32'(cmd_rdy), 0);
        edge_settle();
        drive(0, 1, 3, 1, 0);
        chk("fl_wait_rdy", 32'(cmd_rdy), 0);
        edge_settle();
        chk("fl_wait_fd", 32'(flush_done), 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 3, 1, 1);
            chk("fl_ack_rdy", 32'(cmd_rdy), 0);
            edge_settle();
            chk("fl_ack_cnt", 32'(outstd_cnt), 32'(2 - k));
            chk("fl_ack_fd", 32'(flush_done), (k == 2) ? 1 : 0);
        end
        drive(0, 1, 3, 1, 0);
        chk("fl_after_rdy", 32'(cmd_rdy), 1);
        edge_settle();
        chk("fl_after_fd", 32'(flush_done), 0);
        chk("fl_after_vld", 32'(boram_rd_vld), 1);
        chk("fl_after_par", 32'(boram_rd_parity), 0);
        drive(0, 0, 0, 1, 0);
        edge_settle();
        drive(0, 0, 0, 1, 1);
        edge_settle();
        chk("fl_drain_cnt", 32'(outstd_cnt), 0);

        // Flush requested while a command waits: command still issues, then flush.
        drive(0, 1, 4, 0, 0);
        edge_settle();
        drive(1, 1, 6, 0, 0);
        chk("pend_rdy0", 32'(cmd_rdy), 0);
        edge_settle();
        chk("pend_vld_held", 32'(boram_rd_vld), 1);
        chk("pend_pid_held", 32'(boram_rd_pid), 4);
        drive(0, 1, 6, 1, 0);
        chk("pend_issue_rdy", 32'(cmd_rdy), 0);
        edge_settle();
        chk("pend_issued_cnt", 32'(outstd_cnt), 1);
        chk("pend_issued_vld", 32'(boram_rd_vld), 0);
        drive(0, 1, 6, 1, 1);
        chk("pend_flush_rdy", 32'(cmd_rdy), 0);
        edge_settle();
        chk("pend_fd", 32'(flush_done), 1);
        drive(0, 0, 0, 0, 0);
        edge_settle();
        chk("pend_fd_pulse", 32'(flush_done), 0);

        // Minimum flush latency with nothing outstanding.
        drive(1, 0, 0, 0, 0);
        edge_settle();
        chk("minfl_fd", 32'(flush_done), 1);
        drive(0, 0, 0, 0, 0);
        edge_settle();
        chk("minfl_fd_end", 32'(flush_done), 0);

        // Asynchronous reset mid-operation; late ack then counts as underflow.
        drive(0, 1, 2, 0, 0);
        edge_settle();
        drive(0, 0, 0, 0, 0);
        a_rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(boram_rd_vld), 0);
        chk("arst_cmd_rdy", 32'(cmd_rdy), 0);
        chk("arst_err", 32'(err_underflow), 0);
        @(negedge clk);
        a_rst_n = 1'b1;
        drive(0, 0, 0, 0, 1);
        edge_settle();
        chk("arst_late_ack_err", 32'(err_underflow), 1);
        chk("arst_late_ack_cnt", 32'(outstd_cnt), 0);

        // Random run against a reference parity model.
        drive(0, 0, 0, 0, 0);
        a_rst_n = 1'b0;
        @(negedge clk);
        a_rst_n   = 1'b1;
        model_par = '0;
        model_cnt = 0;
        sent      = 0;
        issued    = 0;
        cyc       = 0;
        pend      = 1'b0;
        pend_pid  = '0;
        while ((issued < int'(N_RAND) || model_cnt != 0) && cyc < int'(RAND_BUDGET)) begin
            @(negedge clk);
            cyc++;
            chk("rand_cnt", 32'(outstd_cnt), 32'(model_cnt));
            if (outstd_cnt > OUTSTD_W'(OUTSTD_MAX)) begin
                chk("rand_cnt_max", 32'(outstd_cnt), OUTSTD_MAX);
            end
            boram_rd_rdy = ($urandom_range(3) != 0);
            do_issue = boram_rd_vld && boram_rd_rdy;
            if (do_issue) begin
                if (exp_q.size() == 0) begin
                    errs++;
                    checks++;
                    $display("FAIL rand_spurious_issue: pid %0d issued with no request pending", boram_rd_pid);
                end else begin
                    exp_pid = exp_q.pop_front();
                    chk("rand_pid", 32'(boram_rd_pid), 32'(exp_pid));
                    chk("rand_par", 32'(boram_rd_parity), 32'(model_par[exp_pid]));
                    model_par[exp_pid] = ~model_par[exp_pid];
                end
                issued++;
                model_cnt++;
                due_q.push_back(cyc + int'($urandom_range(20, 1)));
            end
            do_ack = 1'b0;
            foreach (due_q[j]) begin
                if (!do_ack && due_q[j] <= cyc && !(do_issue && j == due_q.size() - 1)) begin
                    do_ack = 1'b1;
                    due_q.delete(j);
                end
            end
            if (do_ack) begin
                model_cnt--;
            end
            rdata_ack = do_ack;
            if (!pend && sent < int'(N_RAND) && $urandom_range(3) != 0) begin
                pend     = 1'b1;
                pend_pid = 5'($urandom_range(TOTAL_PBS_NB - 1));
            end
            cmd_vld = pend;
            cmd_pid = pend_pid;
            reset_cache = 1'b0;
            #1;
            if (cmd_vld && cmd_rdy) begin
                exp_q.push_back(int'(pend_pid));
                pend = 1'b0;
                sent++;
            end
        end
        if (cyc >= int'(RAND_BUDGET)) begin
            errs++;
            checks++;
            $display("FAIL rand_timeout: issued %0d of %0d, outstanding %0d", issued, N_RAND, model_cnt);
        end
        @(negedge clk);
        cmd_vld   = 1'b0;
        rdata_ack = 1'b0;
        chk("rand_issued_total", 32'(issued), N_RAND);
        chk("rand_final_cnt", 32'(outstd_cnt), 0);
        chk("rand_no_underflow", 32'(err_underflow), 0);
`ifdef PEP_MMACC_BORAM_RD_STATS_EN
        chk("stat_rd_cnt", stat_rd_cnt, N_RAND);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pep_mmacc_boram_rd_ctrl.md
Name: pep_mmacc_boram_rd_ctrl

Overview:
Read-command scheduler in front of pep_mmacc_body_ram, inside the mono-mult-acc (mmacc) sample-extract path. It accepts sample-extract read requests by PID and keeps a per-PID read-parity table. It issues boram_rd_pid/parity/vld commands and limits outstanding reads with a credit counter, which is released when body data is returned. It also sequences a cache flush (reset_cache) so the flush only takes effect when no reads are in flight.

Parameters:
TOTAL_PBS_NB, 32, number of PIDs tracked (from pep_common_param_pkg).
PID_W, $clog2(TOTAL_PBS_NB), PID width.
OUTSTD_MAX, 4, maximum issued-but-unreturned reads (>=1).
OUTSTD_W, $clog2(OUTSTD_MAX+1), outstanding counter width.

Ports:
clk  in  1  clock
a_rst_n  in  1  asynchronous active-low reset
reset_cache  in  1  flush request pulse (level ignored while in FLUSH)
cmd_pid  in  PID_W  requested PID
cmd_vld  in  1  request valid
cmd_rdy  out  1  request accepted when cmd_vld&cmd_rdy
boram_rd_pid  out  PID_W  read PID to body RAM
boram_rd_parity  out  1  read parity to body RAM
boram_rd_vld  out  1  read command valid
boram_rd_rdy  in  1  body RAM accepts command
rdata_ack  in  1  snoop of boram_sxt_data_vld&boram_sxt_data_rdy (one per read)
outstd_cnt  out  OUTSTD_W  current outstanding reads
flush_done  out  1  one-cycle pulse when flush completes
err_underflow  out  1  sticky: rdata_ack seen with outstd_cnt==0

Behaviour:
- Clock and reset: single clock clk. Reset a_rst_n is asynchronous and active-low.
- Reset values: state=ST_IDLE; parity table all 0; outstd_cnt=0; boram_rd_vld=0; boram_rd_pid=0; boram_rd_parity=0; cmd_rdy=0 (combinational, but 0 while reset is asserted); flush_done=0; err_underflow=0.
- FSM states:
  - ST_IDLE: output register empty.
  - ST_REQ: boram_rd_vld=1, command held stable until boram_rd_rdy.
  - ST_STALL: command latched, but outstd_cnt==OUTSTD_MAX, so boram_rd_vld=0.
  - ST_FLUSH: waiting for outstd_cnt==0.
- cmd_rdy: 1 in ST_IDLE with reset_cache=0. Also 1 in ST_REQ when boram_rd_rdy=1, reset_cache=0 and the next credit is available. A credit is available when the next outstd_cnt < OUTSTD_MAX. cmd_rdy is 0 in ST_STALL and ST_FLUSH.
- Accept (cmd_vld&cmd_rdy) in cycle N: in N+1, boram_rd_pid=cmd_pid and boram_rd_parity=parity[cmd_pid] as sampled at N+1. State goes to ST_REQ if a credit is available, else ST_STALL.
- Issue (boram_rd_vld&boram_rd_rdy):
  - parity[boram_rd_pid] toggles.
  - outstd_cnt increments.
  - State goes to ST_IDLE unless a new command is accepted in the same cycle (back-to-back, throughput 1/cycle).
- Same-PID back-to-back: the second command must use the parity after the first issue's toggle. A bypass covers this: parity read uses the toggled value when the PID matches the issuing PID.
- ST_STALL to ST_REQ: when outstd_cnt < OUTSTD_MAX. rdata_ack in the same cycle counts as freeing a credit.
- Counter rules:
  - Issue and rdata_ack in the same cycle: count unchanged.
  - rdata_ack with count 0: count stays 0 and err_underflow is set (sticky until reset).
- Flush:
  - reset_cache seen in ST_IDLE: go to ST_FLUSH.
  - reset_cache seen in ST_REQ or ST_STALL: held pending (1-bit flag) and taken after the current issue completes. The pending command is never dropped.
  - In ST_FLUSH, once outstd_cnt==0: clear the parity table to 0, pulse flush_done for 1 cycle, return to ST_IDLE. Minimum flush latency from ST_IDLE with 0 outstanding is 1 cycle.
- Handshake stability: boram_rd_pid/parity must not change while boram_rd_vld=1 and boram_rd_rdy=0.
- Asynchronous reset mid-operation: all state returns to reset values immediately. In-flight body-RAM data acks arriving after reset are counted as underflow.

Optional Feature:
PEP_MMACC_BORAM_RD_STATS_EN:
- Defined: adds output ports stat_rd_cnt (32 bits, issued reads, wraps) and stat_stall_cycles (32 bits, cycles in ST_STALL, saturating). Both clear on a_rst_n and on flush_done.
- Undefined: these ports and registers do not exist.

Decomposition:
- pep_mmacc_common_param_pkg additions: boram_rd_state_e enum (ST_IDLE, ST_REQ, ST_STALL, ST_FLUSH), OUTSTD_MAX default constant.
- pid_t comes from the existing common package.
- One natural sub-module: pep_mmacc_boram_credit (outstanding counter plus underflow flag), reused by the future data-path arbiters.

Test Plan:
1. Reset, then cmd pid=3 accepted at cycle 0, boram_rd_rdy=1 -> boram_rd_vld=1 with pid=3, parity=0 at cycle 1. A second read of pid 3 issues parity=1. outstd_cnt=2.
2. Back-to-back pid 5,5,5 with boram_rd_rdy held 1, no rdata_ack, OUTSTD_MAX=4 -> parities 0,1,0 in consecutive cycles. A fifth request stalls in ST_STALL after the 4th issue. The first rdata_ack releases it in the same cycle.
3. boram_rd_rdy held 0 for 10 cycles with pid=7 pending -> pid/parity stable, cmd_rdy=0 throughout, exactly one issue when rdy rises.
4. reset_cache pulse with outstd_cnt=3 -> cmd_rdy=0. flush_done pulses 1 cycle after the 3rd rdata_ack. A following read of pid 3 (previous parity 1) issues parity=0.
5. rdata_ack with outstd_cnt=0 -> err_underflow=1 and stays 1; outstd_cnt stays 0.
6. Random 10000-command run against a reference parity model with random boram_rd_rdy and random 1-20 cycle ack latency -> no parity or PID mismatch, outstd_cnt never exceeds 4. With PEP_MMACC_BORAM_RD_STATS_EN defined, stat_rd_cnt=10000.
